// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: one micro-step per clock, all datapath controls from the state.
// Define MIPS_CTRL_HALT_EN to send illegal opcodes/functs to a sticky HALT state instead of FETCH.
module mips_multicycle_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Instruction,
   input  logic        ZeroFlag,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemWrite,
   output logic        MemRead,
   output logic        IRWrite,
   output logic        RegDst,
   output logic        WriteRegSel,
   output logic        MemtoReg,
   output logic        WriteDataSel,
   output logic        RegWrite,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSrc,
   output logic [2:0]  ALUoperation,
   output logic [3:0]  state,
   output logic        halted
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      RTEXE  = 4'd6,
      RTWB   = 4'd7,
      BEQ    = 4'd8,
      IEXE   = 4'd9,
      IWB    = 4'd10,
      JUMP   = 4'd11,
      JR     = 4'd12
`ifdef MIPS_CTRL_HALT_EN
      , HALT = 4'd13
`endif
   } state_t;

`ifdef MIPS_CTRL_HALT_EN
   localparam state_t ILLEGAL_NEXT = HALT;
`else
   localparam state_t ILLEGAL_NEXT = FETCH;
`endif

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     state_q, next_state;
   logic [5:0] opcode, funct;
   logic       pc_write, pc_write_cond, i_or_d, mem_write, mem_read, ir_write;
   logic       reg_dst, write_reg_sel, mem_to_reg, write_data_sel, reg_write, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_op;
`ifdef MIPS_CTRL_HALT_EN
   logic       halt_flag;
`endif
   logic       unused_bits;

   assign opcode = Instruction[31:26];
   assign funct  = Instruction[5:0];
   // The branch decision is made in the datapath (PCWriteCond & ZeroFlag).
   assign unused_bits = ^{Instruction[25:6], ZeroFlag};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= FETCH;
      else      state_q <= next_state;
   end

   always_comb begin
      next_state     = FETCH;
      pc_write       = 1'b0;
      pc_write_cond  = 1'b0;
      i_or_d         = 1'b0;
      mem_write      = 1'b0;
      mem_read       = 1'b0;
      ir_write       = 1'b0;
      reg_dst        = 1'b0;
      write_reg_sel  = 1'b0;
      mem_to_reg     = 1'b0;
      write_data_sel = 1'b0;
      reg_write      = 1'b0;
      alu_src_a      = 1'b0;
      alu_src_b      = 2'b00;
      pc_src         = 2'b00;
      alu_op         = ALU_AND;
`ifdef MIPS_CTRL_HALT_EN
      halt_flag      = 1'b0;
`endif
      case (state_q)
         FETCH: begin
            mem_read   = 1'b1;
            ir_write   = 1'b1;
            alu_src_b  = 2'b01;
            alu_op     = ALU_ADD;
            pc_write   = 1'b1;
            next_state = DECODE;
         end
         DECODE: begin
            // Branch target is precomputed here so BEQ can take it from ALUout.
            alu_src_b = 2'b11;
            alu_op    = ALU_ADD;
            case (opcode)
               OP_RTYPE:         next_state = (funct == FN_JR) ? JR : RTEXE;
               OP_LW, OP_SW:     next_state = MEMADR;
               OP_BEQ:           next_state = BEQ;
               OP_ADDI, OP_SLTI: next_state = IEXE;
               OP_J, OP_JAL:     next_state = JUMP;
               default:          next_state = ILLEGAL_NEXT;
            endcase
         end
         MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alu_op     = ALU_ADD;
            next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            i_or_d     = 1'b1;
            mem_read   = 1'b1;
            next_state = MEMWB;
         end
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         MEMWR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
         end
         RTEXE: begin
            alu_src_a  = 1'b1;
            next_state = RTWB;
            case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               default: next_state = ILLEGAL_NEXT;
            endcase
         end
         RTWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         BEQ: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_src        = 2'b10;
         end
         IEXE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alu_op     = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            next_state = IWB;
         end
         IWB: reg_write = 1'b1;
         JUMP: begin
            pc_src   = 2'b01;
            pc_write = 1'b1;
            // jal links the already-incremented PC into r31.
            if (opcode == OP_JAL) begin
               write_reg_sel  = 1'b1;
               write_data_sel = 1'b1;
               reg_write      = 1'b1;
            end
         end
         JR: begin
            pc_src   = 2'b11;
            pc_write = 1'b1;
         end
`ifdef MIPS_CTRL_HALT_EN
         HALT: begin
            halt_flag  = 1'b1;
            next_state = HALT;
         end
`endif
         default: next_state = FETCH;
      endcase
   end

   // Reset low masks every control asynchronously so an interrupted instruction cannot write.
   assign PCWrite      = rst & pc_write;
   assign PCWriteCond  = rst & pc_write_cond;
   assign IorD         = rst & i_or_d;
   assign MemWrite     = rst & mem_write;
   assign MemRead      = rst & mem_read;
   assign IRWrite      = rst & ir_write;
   assign RegDst       = rst & reg_dst;
   assign WriteRegSel  = rst & write_reg_sel;
   assign MemtoReg     = rst & mem_to_reg;
   assign WriteDataSel = rst & write_data_sel;
   assign RegWrite     = rst & reg_write;
   assign ALUSrcA      = rst & alu_src_a;
   assign ALUSrcB      = rst ? alu_src_b : 2'b00;
   assign PCSrc        = rst ? pc_src : 2'b00;
   assign ALUoperation = rst ? alu_op : 3'b000;
   assign state        = state_q;
`ifdef MIPS_CTRL_HALT_EN
   assign halted       = rst & halt_flag;
`else
   assign halted       = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: an instruction-level model expands each instruction
// word into its expected per-cycle control vectors; one compare process checks every cycle.
module tb_mips_multicycle_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        zero = 1'b0;
   logic        pc_write, pc_write_cond, i_or_d, mem_write, mem_read, ir_write;
   logic        reg_dst, write_reg_sel, mem_to_reg, write_data_sel, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, pc_src;
   logic [2:0]  alu_op;
   logic [3:0]  state;
   logic        halted;

   always #5 clk = ~clk;

   mips_multicycle_controller dut (
      .clk(clk), .rst(rst), .Instruction(instr), .ZeroFlag(zero),
      .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .IorD(i_or_d),
      .MemWrite(mem_write), .MemRead(mem_read), .IRWrite(ir_write),
      .RegDst(reg_dst), .WriteRegSel(write_reg_sel), .MemtoReg(mem_to_reg),
      .WriteDataSel(write_data_sel), .RegWrite(reg_write), .ALUSrcA(alu_src_a),
      .ALUSrcB(alu_src_b), .PCSrc(pc_src), .ALUoperation(alu_op),
      .state(state), .halted(halted)
   );

   // Vector layout: state[23:20] halted PCWrite PCWriteCond IorD MemWrite MemRead IRWrite
   // RegDst WriteRegSel MemtoReg WriteDataSel RegWrite ALUSrcA | ALUSrcB[6:5] PCSrc[4:3] ALUop[2:0]
   logic [23:0] dut_vec;
   assign dut_vec = {state, halted, pc_write, pc_write_cond, i_or_d, mem_write, mem_read,
                     ir_write, reg_dst, write_reg_sel, mem_to_reg, write_data_sel, reg_write,
                     alu_src_a, alu_src_b, pc_src, alu_op};

   localparam logic [12:0] H = 13'h1000, PW = 13'h0800, PWC = 13'h0400, IORD = 13'h0200;
   localparam logic [12:0] MW = 13'h0100, MR = 13'h0080, IRW = 13'h0040, RD = 13'h0020;
   localparam logic [12:0] WRS = 13'h0010, M2R = 13'h0008, WDS = 13'h0004, RW = 13'h0002;
   localparam logic [12:0] ASA = 13'h0001;
   localparam logic [2:0]  A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010;
   localparam logic [2:0]  A_SUB = 3'b110, A_SLT = 3'b111;

   int          total = 0;
   int          bad = 0;
   int          step_n = 0;
   logic [23:0] exp_q[$];

   function automatic logic [23:0] v(input logic [3:0] st, input logic [12:0] f,
                                     input logic [1:0] b, input logic [1:0] p,
                                     input logic [2:0] op);
      return {st, f, b, p, op};
   endfunction

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_illegal();
`ifdef MIPS_CTRL_HALT_EN
      repeat (10) exp_q.push_back(v(4'd13, H, 2'b00, 2'b00, A_AND));
`endif
   endtask

   // Instruction-level model: micro-step list per instruction class.
   task automatic build(input logic [31:0] ins);
      logic [5:0] op, fn;
      logic [2:0] rop;
      bit         rok;
      op = ins[31:26];
      fn = ins[5:0];
      exp_q.push_back(v(4'd0, PW | MR | IRW, 2'b01, 2'b00, A_ADD));
      exp_q.push_back(v(4'd1, 13'h0, 2'b11, 2'b00, A_ADD));
      case (op)
         6'b000000: begin
            if (fn == 6'b001000) exp_q.push_back(v(4'd12, PW, 2'b00, 2'b11, A_AND));
            else begin
               rok = 1'b1;
               rop = A_AND;
               case (fn)
                  6'b100000: rop = A_ADD;
                  6'b100010: rop = A_SUB;
                  6'b100100: rop = A_AND;
                  6'b100101: rop = A_OR;
                  6'b101010: rop = A_SLT;
                  default:   rok = 1'b0;
               endcase
               exp_q.push_back(v(4'd6, ASA, 2'b00, 2'b00, rop));
               if (rok) exp_q.push_back(v(4'd7, RD | RW, 2'b00, 2'b00, A_AND));
               else push_illegal();
            end
         end
         6'b100011: begin
            exp_q.push_back(v(4'd2, ASA, 2'b10, 2'b00, A_ADD));
            exp_q.push_back(v(4'd3, IORD | MR, 2'b00, 2'b00, A_AND));
            exp_q.push_back(v(4'd4, M2R | RW, 2'b00, 2'b00, A_AND));
         end
         6'b101011: begin
            exp_q.push_back(v(4'd2, ASA, 2'b10, 2'b00, A_ADD));
            exp_q.push_back(v(4'd5, IORD | MW, 2'b00, 2'b00, A_AND));
         end
         6'b000100: exp_q.push_back(v(4'd8, ASA | PWC, 2'b00, 2'b10, A_SUB));
         6'b001000, 6'b001010: begin
            exp_q.push_back(v(4'd9, ASA, 2'b10, 2'b00, (op == 6'b001010) ? A_SLT : A_ADD));
            exp_q.push_back(v(4'd10, RW, 2'b00, 2'b00, A_AND));
         end
         6'b000010: exp_q.push_back(v(4'd11, PW, 2'b00, 2'b01, A_AND));
         6'b000011: exp_q.push_back(v(4'd11, PW | WRS | WDS | RW, 2'b00, 2'b01, A_AND));
         default:   push_illegal();
      endcase
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [23:0] e;
         e = exp_q.pop_front();
         check($sformatf("step%0d_state%0d", step_n, e[23:20]), dut_vec, e);
         step_n++;
      end
   end

   // Called during a FETCH cycle, before its falling edge; returns in the next cycle.
   task automatic run_instr(input logic [31:0] ins, input logic z);
      int n;
      instr = ins;
      zero  = z;
      build(ins);
      n = 0;
      while (exp_q.size() > 0 && n < 30) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (exp_q.size() > 0) begin
         check("seq_timeout", 24'(exp_q.size()), 24'h0);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("rst_async", dut_vec, 24'h0);
      repeat (3) begin
         @(negedge clk);
         check("rst_hold", dut_vec, 24'h0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("first_fetch", dut_vec, 24'h046022);
   endtask

   initial begin
      // Pin the model to hand-computed vectors.
      build(32'h10220003);
      check("pin_fetch", exp_q[0], 24'h046022);
      check("pin_beq", exp_q[2], 24'h820096);
      exp_q.delete();
      build(32'h03E00008);
      check("pin_jr", exp_q[2], 24'hC40018);
      exp_q.delete();

      @(posedge clk);
      #1;
      do_reset();

      run_instr(32'h8C220004, 1'b0);   // lw
      run_instr(32'hAC220004, 1'b0);   // sw
      run_instr(32'h00221822, 1'b0);   // sub
      run_instr(32'h0022182A, 1'b0);   // slt
      run_instr(32'h00221820, 1'b0);   // add
      run_instr(32'h00221824, 1'b0);   // and
      run_instr(32'h00221825, 1'b0);   // or
      run_instr(32'h10220003, 1'b1);   // beq, taken
      run_instr(32'h10220003, 1'b0);   // beq, not taken
      run_instr(32'h20220005, 1'b0);   // addi
      run_instr(32'h28220005, 1'b0);   // slti
      run_instr(32'h08000010, 1'b0);   // j
      run_instr(32'h0C000010, 1'b0);   // jal
      run_instr(32'h03E00008, 1'b0);   // jr

      // Reset in the middle of a lw.
      instr = 32'h8C220004;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("pre_rst_state", 24'(state), 24'd2);
      do_reset();
      run_instr(32'h20220005, 1'b0);

      run_instr(32'h00000001, 1'b0);   // illegal funct
      do_reset();
      run_instr(32'hFC000000, 1'b0);   // illegal opcode
      do_reset();
      run_instr(32'hFC000000, 1'b0);
      run_instr(32'h00221822, 1'b0);
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
